handshake_ctrl_extract: RTL and testbench

Data-to-control end of the elastic handshake fabric: consumes tokens from a data channel, discards the payload, and emits one dataless control token per input token on a ctrl channel. Each control token carries a match flag: whether the payload equalled the compile-time constant. This is the inverse of the constant-generator blocks, which turn control tokens into constant data. A 2-entry skid buffer makes both ready and valid registered, so the block can break combinational handshake paths between dataflow regions. A saturating counter of delivered tokens supports debug and verification.

---
 rtl/handshake_ctrl_extract_pkg.sv | 25 ++
 rtl/handshake_ctrl_extract_skid.sv | 96 +++++++++
 rtl/handshake_ctrl_extract.sv | 61 ++++++
 tb/tb_handshake_ctrl_extract.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/handshake_ctrl_extract_pkg.sv
// Shared handshake definitions for the elastic fabric blocks.
//   occ_state_t : occupancy of a 2-entry elastic buffer
//   sat_inc     : saturating increment used by counting handshake blocks
package handshake_ctrl_extract_pkg;

  localparam int unsigned SAT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  // Increment value by one unless it has already reached max_value.
  function automatic logic [SAT_WIDTH-1:0] sat_inc(
    input logic [SAT_WIDTH-1:0] value,
    input logic [SAT_WIDTH-1:0] max_value
  );
    if (value >= max_value) begin
      return value;
    end
    return value + SAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/handshake_ctrl_extract_skid.sv
// handshake_skid_buffer: 2-entry elastic buffer with registered ready and valid.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   push_data/push_valid/push_ready  upstream channel (push_ready registered)
//   pop_data/pop_valid/pop_ready     downstream channel (pop_valid/pop_data registered)
module handshake_skid_buffer
  import handshake_ctrl_extract_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready
);

  occ_state_t       state_q;
  occ_state_t       state_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             ready_q;
  logic             ready_d;
  logic             valid_q;
  logic             valid_d;
  logic             push;
  logic             pop;

  // Handshakes are qualified by our own registered ready/valid, so pop_ready
  // never reaches push_ready combinationally.
  assign push = push_valid && ready_q;
  assign pop  = valid_q && pop_ready;

  // State register and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Occupancy next-state and entry routing.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = push_data;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          skid_d  = push_data;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          // Head leaves and the new entry replaces it in the same cycle.
          head_d = push_data;
        end
      end
      TWO: begin
        // push cannot happen here: ready_q is low while full.
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != TWO);
  end

  assign push_ready = ready_q;
  assign pop_valid  = valid_q;
  assign pop_data   = head_q;

endmodule

// File: rtl/handshake_ctrl_extract.sv
// handshake_ctrl_extract: turns data tokens into dataless control tokens that
// carry a flag telling whether the payload equalled CONST_VALUE.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ins/ins_valid         input data channel; ins_ready registered
//   ctrl_valid/ctrl_ready output control channel; ctrl_valid registered
//   ctrl_match            flag of the head token
//   token_count           saturating count of delivered control tokens
module handshake_ctrl_extract
  import handshake_ctrl_extract_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] CONST_VALUE = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  ctrl_valid,
  input  logic                  ctrl_ready,
  output logic                  ctrl_match,
  output logic [CNT_WIDTH-1:0]  token_count
);

  localparam logic [DATA_WIDTH-1:0] MATCH_VALUE = DATA_WIDTH'(CONST_VALUE);
  localparam logic [SAT_WIDTH-1:0]  CNT_MAX     =
    SAT_WIDTH'((64'd1 << CNT_WIDTH) - 64'd1);

  logic                 match;
  logic [CNT_WIDTH-1:0] count_q;

  // Only the comparison result is stored; the payload is dropped here.
  assign match = (ins == MATCH_VALUE);

  handshake_skid_buffer #(
    .WIDTH (1)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_data  (match),
    .push_valid (ins_valid),
    .push_ready (ins_ready),
    .pop_data   (ctrl_match),
    .pop_valid  (ctrl_valid),
    .pop_ready  (ctrl_ready)
  );

  // Delivered-token counter, holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (ctrl_valid && ctrl_ready) begin
      count_q <= CNT_WIDTH'(sat_inc(SAT_WIDTH'(count_q), CNT_MAX));
    end
  end

  assign token_count = count_q;

endmodule

// File: tb/tb_handshake_ctrl_extract.sv
module tb_handshake_ctrl_extract;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_WIDTH = 16).
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        ctrl_match;
  logic [15:0] token_count;

  // Small-counter instance (CNT_WIDTH = 2).
  logic        rst2;
  logic [31:0] ins2;
  logic        ins_valid2;
  logic        ins_ready2;
  logic        ctrl_valid2;
  logic        ctrl_ready2;
  logic        ctrl_match2;
  logic [1:0]  token_count2;

  int checks = 0;
  int errors = 0;

  handshake_ctrl_extract #(
    .DATA_WIDTH  (32),
    .CONST_VALUE (32'h0000_0013),
    .CNT_WIDTH   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ins         (ins),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .ctrl_match  (ctrl_match),
    .token_count (token_count)
  );

  handshake_ctrl_extract #(
    .DATA_WIDTH  (32),
    .CONST_VALUE (32'h0000_0013),
    .CNT_WIDTH   (2)
  ) dut2 (
    .clk         (clk),
    .rst         (rst2),
    .ins         (ins2),
    .ins_valid   (ins_valid2),
    .ins_ready   (ins_ready2),
    .ctrl_valid  (ctrl_valid2),
    .ctrl_ready  (ctrl_ready2),
    .ctrl_match  (ctrl_match2),
    .token_count (token_count2)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ins;
    logic        cr;
    logic        rdy;
    logic        vld;
    int          m;    // expected ctrl_match, 2 = not checked
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic cr,
                     input logic rdy, input logic vld, input int m, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.ins = d; v.cr = cr;
    v.rdy = rdy; v.vld = vld; v.m = m; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  bit          q[$];
  logic [15:0] cnt_m;
  logic [1:0]  exp2[5];

  initial begin
    rst = 1'b1; ins = '0; ins_valid = 1'b0; ctrl_ready = 1'b0;
    rst2 = 1'b1; ins2 = '0; ins_valid2 = 1'b0; ctrl_ready2 = 1'b0;

    //   rst iv  ins     cr   rdy vld match cnt  (expected after the edge)
    // reset held with ins_valid high
    add(1, 1, 32'h13, 1,   0,  0,  0,    0);
    add(1, 1, 32'h13, 1,   0,  0,  0,    0);
    add(1, 1, 32'h13, 1,   0,  0,  0,    0);
    // release: ready rises on first edge
    add(0, 0, 32'h00, 1,   1,  0,  2,    0);
    // stream 0x13, 0x14, 0x13 with ctrl_ready high
    add(0, 1, 32'h13, 1,   1,  1,  1,    0);
    add(0, 1, 32'h14, 1,   1,  1,  0,    1);
    add(0, 1, 32'h13, 1,   1,  1,  1,    2);
    add(0, 0, 32'h00, 1,   1,  0,  2,    3);
    // backpressure: 0x13, 0x00 stored, 0x13 refused
    add(0, 1, 32'h13, 0,   1,  1,  1,    3);
    add(0, 1, 32'h00, 0,   0,  1,  1,    3);
    add(0, 1, 32'h13, 0,   0,  1,  1,    3);
    add(0, 1, 32'h13, 0,   0,  1,  1,    3);
    // release ctrl_ready: 1 out, then 0 out while third token enters
    add(0, 1, 32'h13, 1,   1,  1,  0,    4);
    add(0, 1, 32'h13, 1,   1,  1,  1,    5);
    add(0, 0, 32'h00, 1,   1,  0,  2,    6);
    // empty: ctrl_ready ignored
    add(0, 0, 32'h00, 1,   1,  0,  2,    6);
    // fill to TWO, then reset mid-operation
    add(0, 1, 32'h13, 0,   1,  1,  1,    6);
    add(0, 1, 32'h13, 0,   0,  1,  1,    6);
    add(1, 1, 32'h13, 1,   0,  0,  2,    0);
    add(0, 0, 32'h00, 1,   1,  0,  2,    0);
    add(0, 0, 32'h00, 1,   1,  0,  2,    0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; ins_valid = vecs[i].iv; ins = vecs[i].ins; ctrl_ready = vecs[i].cr;
      @(posedge clk); #1;
      check($sformatf("v%0d ins_ready", i), 32'(ins_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d ctrl_valid", i), 32'(ctrl_valid), 32'(vecs[i].vld));
      if (vecs[i].m != 2)
        check($sformatf("v%0d ctrl_match", i), 32'(ctrl_match), 32'(vecs[i].m));
      check($sformatf("v%0d token_count", i), 32'(token_count), 32'(vecs[i].cnt));
    end

    // Random valid/ready against a queue model; block is empty with count 0.
    cnt_m = 16'd0;
    for (int c = 0; c < 104; c++) begin
      bit acc;
      bit del;
      if (c < 100) begin
        ins_valid  = 1'($urandom_range(0, 1));
        ctrl_ready = ($urandom_range(0, 3) != 0);
        ins        = ($urandom_range(0, 1) != 0) ? 32'h13 : 32'($urandom);
      end else begin
        ins_valid  = 1'b0;
        ctrl_ready = 1'b1;
      end
      acc = ins_valid && (q.size() < 2);
      del = ctrl_ready && (q.size() > 0);
      if (del) begin
        void'(q.pop_front());
        if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      end
      if (acc) q.push_back(ins == 32'h13);
      @(posedge clk); #1;
      check($sformatf("r%0d ins_ready", c), 32'(ins_ready), 32'(q.size() < 2));
      check($sformatf("r%0d ctrl_valid", c), 32'(ctrl_valid), 32'(q.size() > 0));
      check($sformatf("r%0d token_count", c), 32'(token_count), 32'(cnt_m));
      if (q.size() > 0)
        check($sformatf("r%0d ctrl_match", c), 32'(ctrl_match), 32'(q[0]));
    end

    // Saturation on the 2-bit counter instance.
    exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
    @(posedge clk); #1;
    rst2 = 1'b0; ins2 = 32'h13; ins_valid2 = 1'b1; ctrl_ready2 = 1'b1;
    @(posedge clk); #1;
    check("sat ready_after_release", 32'(ins_ready2), 32'd1);
    check("sat count_before", 32'(token_count2), 32'd0);
    @(posedge clk); #1;
    check("sat first_valid", 32'(ctrl_valid2), 32'd1);
    check("sat count_first_accept", 32'(token_count2), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("sat count%0d", k), 32'(token_count2), 32'(exp2[k]));
      check($sformatf("sat valid%0d", k), 32'(ctrl_valid2), 32'd1);
      check($sformatf("sat match%0d", k), 32'(ctrl_match2), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
